// File: rtl/cga_isa_vram_port_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cga_isa_vram_port_if : ISA-side and VRAM-side signal bundle of the CPU port
// Rev 1.0
// ---------------------------------------------------------------------------
interface cga_isa_vram_port_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  bus_sel;
    logic                  bus_memr_n;
    logic                  bus_memw_n;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [7:0]            bus_din;
    logic [7:0]            bus_dout;
    logic                  bus_wait;
    logic [ADDR_WIDTH-1:0] vram_addr;
    logic [7:0]            vram_wdata;
    logic                  vram_we;
    logic                  vram_oe;
    logic [7:0]            vram_rdata;

    modport slave (
        input  bus_sel, bus_memr_n, bus_memw_n, bus_addr, bus_din, vram_rdata,
        output bus_dout, bus_wait, vram_addr, vram_wdata, vram_we, vram_oe
    );

    modport master (
        output bus_sel, bus_memr_n, bus_memw_n, bus_addr, bus_din, vram_rdata,
        input  bus_dout, bus_wait, vram_addr, vram_wdata, vram_we, vram_oe
    );
endinterface
`default_nettype wire

// File: rtl/cga_isa_vram_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cga_isa_vram_port : CPU VRAM access port, ops confined to sequencer windows
// Rev 1.0
// ---------------------------------------------------------------------------
module cga_isa_vram_port #(
    parameter int ADDR_WIDTH  = 14,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          isa_op_enable,
    cga_isa_vram_port_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_WIN = 3'd1,
        ST_C1       = 3'd2,
        ST_C2       = 3'd3,
        ST_C3       = 3'd4,
        ST_HOLD     = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic [SYNC_STAGES-1:0] r_memr_sync;
    logic [SYNC_STAGES-1:0] r_memw_sync;
    logic                   w_s_sel;
    logic                   w_s_rd;
    logic                   w_s_wr;

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [7:0]             r_wdata;
    logic [7:0]             r_dout;
    logic                   r_is_write;
    logic                   r_oe;
    logic                   r_we;
    logic                   r_done;
    logic                   w_latch;
    logic                   w_cpu_cycle_next;
    logic                   w_we_next;

    // Strobes idle high, so their synchronizers clear to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_sync  <= '0;
            r_memr_sync <= '1;
            r_memw_sync <= '1;
        end else begin
            r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0],  bus.bus_sel};
            r_memr_sync <= {r_memr_sync[SYNC_STAGES-2:0], bus.bus_memr_n};
            r_memw_sync <= {r_memw_sync[SYNC_STAGES-2:0], bus.bus_memw_n};
        end
    end

    assign w_s_sel = r_sel_sync[SYNC_STAGES-1];
    assign w_s_rd  = ~r_memr_sync[SYNC_STAGES-1];
    assign w_s_wr  = ~r_memw_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s_sel && (w_s_wr || w_s_rd)) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_WAIT_WIN;
                end
            end
            ST_WAIT_WIN: begin
                if (isa_op_enable) begin
                    w_state_next = ST_C1;
                end
            end
            ST_C1:   w_state_next = ST_C2;
            ST_C2:   w_state_next = ST_C3;
            ST_C3:   w_state_next = ST_HOLD;
            ST_HOLD: begin
                if (!w_s_rd && !w_s_wr) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with C1..C3.
    assign w_cpu_cycle_next = (w_state_next == ST_C1) || (w_state_next == ST_C2) ||
                              (w_state_next == ST_C3);
    assign w_we_next        = r_is_write &&
                              ((w_state_next == ST_C1) || (w_state_next == ST_C2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_oe       <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_dout     <= '0;
        end else begin
            if (w_latch) begin
                r_addr     <= bus.bus_addr;
                r_wdata    <= bus.bus_din;
                r_is_write <= w_s_wr;
            end
            r_oe   <= w_cpu_cycle_next;
            r_we   <= w_we_next;
            r_done <= (w_state_next == ST_HOLD);
            if ((r_state == ST_C3) && !r_is_write) begin
                r_dout <= bus.vram_rdata;
            end
        end
    end

    // Raw bus inputs here so the hold is seen before the ISA ready sample point.
    assign bus.bus_wait   = bus.bus_sel & (~bus.bus_memr_n | ~bus.bus_memw_n) & ~r_done;
    assign bus.bus_dout   = r_dout;
    assign bus.vram_addr  = r_addr;
    assign bus.vram_wdata = r_wdata;
    assign bus.vram_we    = r_we;
    assign bus.vram_oe    = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_cga_isa_vram_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cga_isa_vram_port : scoreboard bench for the CPU VRAM access port
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cga_isa_vram_port;

    localparam int AW = 14;
    localparam int SS = 2;

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    dout;
    } op_t;

    logic clk           = 1'b0;
    logic reset_n       = 1'b0;
    logic isa_op_enable = 1'b0;

    always #5 clk = ~clk;

    cga_isa_vram_port_if #(.ADDR_WIDTH(AW)) bus_if ();

    cga_isa_vram_port #(
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .isa_op_enable (isa_op_enable),
        .bus           (bus_if.slave)
    );

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         ops_seen  = 0;
    op_t        sb_q[$];
    logic [7:0] last_read = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Enable as the DUT saw it at the last rising edge.
    logic en_at_edge = 1'b0;
    always @(posedge clk) en_at_edge <= isa_op_enable;

    logic          in_op  = 1'b0;
    logic [2:0]    we_pat = 3'b000;
    int            oe_len = 0;
    logic [AW-1:0] op_addr;
    logic [7:0]    op_wdata;
    op_t           exp_op;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_op = 1'b0;
        end else if (bus_if.vram_oe) begin
            if (!in_op) begin
                in_op    = 1'b1;
                oe_len   = 0;
                we_pat   = 3'b000;
                op_addr  = bus_if.vram_addr;
                op_wdata = bus_if.vram_wdata;
                check_eq("win_open", {31'd0, en_at_edge}, 32'd1);
            end
            we_pat = {we_pat[1:0], bus_if.vram_we};
            oe_len++;
        end else if (in_op) begin
            in_op = 1'b0;
            ops_seen++;
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_op = sb_q.pop_front();
                check_eq("op_addr", {18'd0, op_addr}, {18'd0, exp_op.addr});
                check_eq("op_we_pat", {29'd0, we_pat}, exp_op.is_wr ? 32'd6 : 32'd0);
                check_eq("op_oe_len", oe_len, 32'd3);
                if (exp_op.is_wr) check_eq("op_wdata", {24'd0, op_wdata}, {24'd0, exp_op.wdata});
                check_eq("op_dout", {24'd0, bus_if.bus_dout}, {24'd0, exp_op.dout});
            end
        end
    end

    task automatic start_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [7:0] d, input logic [7:0] rdat);
        op_t e;
        bus_if.vram_rdata = rdat;
        bus_if.bus_addr   = a;
        bus_if.bus_din    = d;
        bus_if.bus_sel    = 1'b1;
        bus_if.bus_memr_n = ~rd;
        bus_if.bus_memw_n = ~wr;
        if (!wr) last_read = rdat;
        e.is_wr = wr;
        e.addr  = a;
        e.wdata = d;
        e.dout  = last_read;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.bus_wait && n < 200);
        if (bus_if.bus_wait) check_eq("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic release_bus(input int gap);
        bus_if.bus_sel    = 1'b0;
        bus_if.bus_memr_n = 1'b1;
        bus_if.bus_memw_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus_if.bus_sel    = 1'b0;
        bus_if.bus_memr_n = 1'b1;
        bus_if.bus_memw_n = 1'b1;
        bus_if.bus_addr   = '0;
        bus_if.bus_din    = '0;
        bus_if.vram_rdata = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_oe",    {31'd0, bus_if.vram_oe}, 32'd0);
        check_eq("rst_we",    {31'd0, bus_if.vram_we}, 32'd0);
        check_eq("rst_addr",  {18'd0, bus_if.vram_addr}, 32'd0);
        check_eq("rst_wdata", {24'd0, bus_if.vram_wdata}, 32'd0);
        check_eq("rst_dout",  {24'd0, bus_if.bus_dout}, 32'd0);
        check_eq("rst_wait",  {31'd0, bus_if.bus_wait}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Open-window write
        isa_op_enable = 1'b1;
        start_op(1'b0, 1'b1, 14'h1234, 8'hA5, 8'h00);
        #1 check_eq("wait_comb", {31'd0, bus_if.bus_wait}, 32'd1);
        wait_done(n);
        check_eq("wr_latency", n, SS + 5);
        release_bus(4);

        // Closed-window read
        isa_op_enable = 1'b0;
        start_op(1'b1, 1'b0, 14'h0ABC, 8'h00, 8'h3C);
        repeat (8) @(negedge clk);
        check_eq("wait_closed", {31'd0, bus_if.bus_wait}, 32'd1);
        check_eq("oe_closed",   {31'd0, bus_if.vram_oe}, 32'd0);
        isa_op_enable = 1'b1;
        wait_done(n);
        check_eq("rd_dout", {24'd0, bus_if.bus_dout}, 32'h3C);
        release_bus(4);

        // Single-cycle window pulse
        isa_op_enable = 1'b0;
        start_op(1'b0, 1'b1, 14'h0200, 8'h5F, 8'h00);
        repeat (SS + 3) @(negedge clk);
        isa_op_enable = 1'b1;
        @(negedge clk);
        isa_op_enable = 1'b0;
        wait_done(n);
        release_bus(4);
        isa_op_enable = 1'b1;

        // Both strobes: write wins
        start_op(1'b1, 1'b1, 14'h0010, 8'h77, 8'hEE);
        wait_done(n);
        repeat (6) @(negedge clk);
        release_bus(4);
        check_eq("both_dout", {24'd0, bus_if.bus_dout}, 32'h3C);

        // Back-to-back writes
        start_op(1'b0, 1'b1, 14'h0001, 8'h11, 8'h00);
        wait_done(n);
        release_bus(3);
        start_op(1'b0, 1'b1, 14'h0002, 8'h22, 8'h00);
        wait_done(n);
        release_bus(4);

        // Reset during C2 of a read
        start_op(1'b1, 1'b0, 14'h3FFF, 8'h00, 8'h5A);
        n = 0;
        while (!bus_if.vram_oe && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("oe_seen", {31'd0, bus_if.vram_oe}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_oe",   {31'd0, bus_if.vram_oe}, 32'd0);
        check_eq("arst_we",   {31'd0, bus_if.vram_we}, 32'd0);
        check_eq("arst_wait", {31'd0, bus_if.bus_wait}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        wait_done(n);
        check_eq("rerd_dout", {24'd0, bus_if.bus_dout}, 32'h5A);
        release_bus(4);

        check_eq("sb_drained", sb_q.size(), 32'd0);
        check_eq("op_count", ops_seen, 32'd7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cga_isa_vram_port.md
Name: cga_isa_vram_port

Overview:
- CPU-side VRAM access port of the CGA video block; responds to ISA memory reads and writes aimed at video RAM.
- Services each bus request only inside the access windows granted by the video sequencer (isa_op_enable), so CPU accesses never collide with display fetches.
- Holds the ISA bus with IOCHRDY-style wait until the 3-cycle VRAM operation completes.
- Sits between the ISA bus decode logic and the VRAM mux, opposite the sequencer's display-fetch side.

Parameters:
- ADDR_WIDTH, 14, VRAM byte address width (14 = 16 KB CGA; 15 for Tandy 32 KB).
- SYNC_STAGES, 2, flip-flop depth of the ISA strobe/select synchronizers (minimum 2).

Ports:
- clk  in  1  video clock, same clock as the sequencer.
- reset_n  in  1  asynchronous, active-low reset.
- isa_op_enable  in  1  sequencer grant window; a VRAM op may start only while this is high.
- bus_sel  in  1  asynchronous; address decode hit for VRAM range.
- bus_memr_n  in  1  asynchronous ISA MEMR#, active low.
- bus_memw_n  in  1  asynchronous ISA MEMW#, active low.
- bus_addr  in  ADDR_WIDTH  ISA address, stable while strobe active.
- bus_din  in  8  ISA write data.
- bus_dout  out  8  read data returned to ISA.
- bus_wait  out  1  high = hold bus (drives IOCHRDY low externally).
- vram_addr  out  ADDR_WIDTH  VRAM address during CPU op.
- vram_wdata  out  8  VRAM write data.
- vram_we  out  1  VRAM write enable.
- vram_oe  out  1  VRAM read enable / CPU owns VRAM mux.
- vram_rdata  in  8  VRAM read data.

Behaviour:
- Reset (async, reset_n low): state IDLE; bus_dout=0, vram_addr=0, vram_wdata=0, vram_we=0, vram_oe=0; synchronizers cleared to inactive (sel=0, strobes=1).
- Synchronize bus_sel, bus_memr_n and bus_memw_n through SYNC_STAGES flops; call the results s_sel, s_rd, s_wr (active high). Requests are level-based, not edge-based.
- bus_wait is combinational: bus_sel & (~bus_memr_n | ~bus_memw_n) & ~done, using the raw inputs so wait asserts before the ISA sample point. done is a registered flag, high only in HOLD.
- FSM:
  - IDLE: if s_sel & (s_wr | s_rd), latch bus_addr into vram_addr, bus_din into vram_wdata and a direction bit (write wins if both strobes are active), then go to WAIT_WIN.
  - WAIT_WIN: if isa_op_enable is high this cycle, go to C1; otherwise stay.
  - C1: vram_oe=1; vram_we=1 if write.
  - C2: vram_oe=1; vram_we=1 if write.
  - C3: vram_oe=1; vram_we=0; on a read, capture vram_rdata into bus_dout at the end of C3. Then go to HOLD.
  - HOLD: done=1, so bus_wait deasserts. Remain until both s_rd and s_wr are inactive, then return to IDLE.
- vram_oe and vram_we are registered, asserted only in C1..C3, and never high outside that span.
- isa_op_enable is sampled only at WAIT_WIN exit. Once C1 starts, the op always completes C1..C3 even if the window closes (sequencer guarantees a ≥2-cycle gap).
- Latency, synced request to done, if the window is open: 1 (IDLE) + 1 (WAIT_WIN) + 3 (C1..C3) = 5 clk, plus synchronizer delay. Worst case adds one closed-window span.
- The strobe is released while not in HOLD (aborted bus cycle): the op in flight completes, no retry. HOLD exits immediately.
- bus_sel drops mid-op: ignored after the IDLE latch.
- bus_dout holds its last read value until the next read's C3; writes do not alter it.
- Back-to-back requests need the strobe to go inactive (HOLD to IDLE) before a new op starts; one op per strobe assertion.
- Reset mid-op: outputs are cleared immediately. If the strobe is still low after reset, the request is re-serviced from IDLE once the synchronizers fill, and bus_wait stays high throughout.

Test Plan:
- Write in open window: isa_op_enable held 1, sel=1, MEMW# low, addr=0x1234, data=0xA5 -> vram_we high exactly 2 clk at addr 0x1234 with wdata 0xA5; bus_wait falls 5 clk after s_wr rises.
- Read with closed window: vram_rdata=0x3C, enable low for 8 clk then high -> no vram_oe while low; oe high 3 clk after enable; bus_dout=0x3C; bus_wait high until HOLD.
- Window closes at C1: enable is a single-cycle pulse -> C1..C3 complete in full; vram_we pattern 1,1,0.
- Both strobes low: addr=0x0010, din=0x77 -> write performed, no bus_dout change, single op only.
- Back-to-back: two writes (0x0001/0x11, 0x0002/0x22) with a 3 clk strobe-high gap -> two distinct ops; second starts only after HOLD sees the release.
- Reset mid-op: reset_n pulsed low during C2 of a read -> oe/we drop asynchronously; with MEMR# still low, the read re-completes after release and bus_dout is correct.
